// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver
// Time-multiplexed driver for a bank of common-anode seven-segment digits.
// A shadow register holds the displayed hex value. One digit is selected per
// refresh slot, and the first GUARD clocks of each slot keep every anode off
// to stop ghosting. Every output is registered, so the outputs lag the
// (cnt, idx, shadow) state by one clock.
module sevenseg_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int GUARD          = 1,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit INVERT_IN      = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dpIn,
  input  logic                  blankLead,
  input  logic                  enable,
  output logic [6:0]            disp,
  output logic                  dp,
  output logic [DIGITS-1:0]     anode,
  output logic                  scanTick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [4*DIGITS-1:0] shadow;
  logic [DIGITS-1:0]   dpShadow;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;

  logic                cntWrap;
  logic                idxWrap;
  logic [3:0]          curNibble;
  logic                curDp;
  logic                upperZero;
  logic                blankDigit;
  logic                slotActive;
  logic [DIGITS-1:0]   anodeSel;
  logic [DIGITS-1:0]   anodeNext;
  logic [6:0]          segsNext;
  logic                dpNext;

  assign cntWrap = (cnt == CNT_LAST);
  assign idxWrap = (idx == IDX_LAST);

  // Capture the displayed value. Polarity inversion of the input happens here, so the rest of the logic sees true hex.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      shadow   <= '0;
      dpShadow <= '0;
    end else if (load) begin
      shadow   <= value ^ {(4*DIGITS){INVERT_IN}};
      dpShadow <= dpIn;
    end
  end

  // Prescaler and digit index. The scan keeps running while the display is disabled.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt <= '0;
      idx <= '0;
    end else if (cntWrap) begin
      cnt <= '0;
      idx <= idxWrap ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Select the current digit, work out leading-zero blanking, and gate the anode with the guard and enable.
  always_comb begin
    curNibble = 4'h0;
    curDp     = 1'b0;
    upperZero = 1'b1;
    anodeSel  = '0;
    for (int j = 0; j < DIGITS; j++) begin
      if (IDX_W'(j) == idx) begin
        curNibble   = shadow[4*j +: 4];
        curDp       = dpShadow[j];
        anodeSel[j] = 1'b1;
      end
      if ((IDX_W'(j) >= idx) && (shadow[4*j +: 4] != 4'h0)) begin
        upperZero = 1'b0;
      end
    end
    blankDigit = blankLead && (idx != '0) && upperZero;
    slotActive = enable && (cnt >= CNT_GUARD);
    anodeNext  = slotActive ? anodeSel : '0;
  end

  // Active-high gfedcba decode. A blanked digit turns off every segment and the dp.
  always_comb begin
    segsNext = 7'b0000000;
    case (curNibble)
      4'h0: segsNext = 7'b0111111;
      4'h1: segsNext = 7'b0000110;
      4'h2: segsNext = 7'b1011011;
      4'h3: segsNext = 7'b1001111;
      4'h4: segsNext = 7'b1100110;
      4'h5: segsNext = 7'b1101101;
      4'h6: segsNext = 7'b1111101;
      4'h7: segsNext = 7'b0000111;
      4'h8: segsNext = 7'b1111111;
      4'h9: segsNext = 7'b1101111;
      4'hA: segsNext = 7'b1110111;
      4'hB: segsNext = 7'b1111100;
      4'hC: segsNext = 7'b0111001;
      4'hD: segsNext = 7'b1011110;
      4'hE: segsNext = 7'b1111001;
      default: segsNext = 7'b1110001;
    endcase
    dpNext = curDp;
    if (blankDigit) begin
      segsNext = 7'b0000000;
      dpNext   = 1'b0;
    end
  end

  // Output registers. Board polarity is applied only at this stage.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      disp     <= {7{SEG_ACTIVE_LOW}};
      dp       <= SEG_ACTIVE_LOW;
      anode    <= {DIGITS{AN_ACTIVE_LOW}};
      scanTick <= 1'b0;
    end else begin
      disp     <= segsNext ^ {7{SEG_ACTIVE_LOW}};
      dp       <= dpNext ^ SEG_ACTIVE_LOW;
      anode    <= anodeNext ^ {DIGITS{AN_ACTIVE_LOW}};
      scanTick <= cntWrap && idxWrap;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb_sevenseg_scan_driver
// Directed bench for two 4-digit, 4-clock-slot drivers. The first instance
// uses plain input and the second uses inverted input. All expected
// segment, dp and anode values below are hand-decoded for active-low pins.
module tb_sevenseg_scan_driver;

  logic        clk = 1'b0;
  logic        rstN;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dpIn;
  logic        blankLead;
  logic        enable;

  logic [6:0]  disp, dispInv;
  logic        dp, dpInv;
  logic [3:0]  anode, anodeInv;
  logic        scanTick, scanTickInv;

  int testsRun    = 0;
  int testsFailed = 0;

  sevenseg_scan_driver #(
    .DIGITS(4), .REFRESH_DIV(4), .GUARD(1),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .INVERT_IN(1'b0)
  ) dut (
    .clk(clk), .rstN(rstN), .load(load), .value(value), .dpIn(dpIn),
    .blankLead(blankLead), .enable(enable),
    .disp(disp), .dp(dp), .anode(anode), .scanTick(scanTick)
  );

  sevenseg_scan_driver #(
    .DIGITS(4), .REFRESH_DIV(4), .GUARD(1),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .INVERT_IN(1'b1)
  ) dutInv (
    .clk(clk), .rstN(rstN), .load(load), .value(value), .dpIn(dpIn),
    .blankLead(blankLead), .enable(enable),
    .disp(dispInv), .dp(dpInv), .anode(anodeInv), .scanTick(scanTickInv)
  );

  // Free-running clock with a 10 time-unit period.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d, input logic blank);
    value     = v;
    dpIn      = d;
    blankLead = blank;
    load      = 1'b1;
    tick();
    load      = 1'b0;
  endtask

  task automatic waitScanTick();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!scanTick && n < 40);
    checkOutput("scanTickSeen", 32'(scanTick), 32'd1);
  endtask

  // Checks one full scan that starts right after a wrap. Digit s sits at expDisp[7*s +: 7].
  task automatic checkScan(input bit useInv, input logic [27:0] expDisp, input logic [3:0] expDp, input string tag);
    logic [3:0] expAn;
    waitScanTick();
    for (int s = 0; s < 4; s++) begin
      expAn = 4'hF ^ (4'h1 << s);
      tick();
      checkOutput($sformatf("%s d%0d guard", tag, s), 32'(useInv ? anodeInv : anode), 32'hF);
      tick();
      tick();
      tick();
      checkOutput($sformatf("%s d%0d anode", tag, s), 32'(useInv ? anodeInv : anode), 32'(expAn));
      checkOutput($sformatf("%s d%0d disp", tag, s), 32'(useInv ? dispInv : disp), 32'(expDisp[7*s +: 7]));
      checkOutput($sformatf("%s d%0d dp", tag, s), 32'(useInv ? dpInv : dp), 32'(expDp[s]));
    end
    checkOutput($sformatf("%s cadence", tag), 32'(scanTick), 32'd1);
  endtask

  initial begin
    int n;
    rstN = 1'b0; load = 1'b0; value = 16'h0; dpIn = 4'h0; blankLead = 1'b0; enable = 1'b1;
    tick();
    tick();
    checkOutput("reset anode", 32'(anode), 32'hF);
    checkOutput("reset disp", 32'(disp), 32'h7F);
    checkOutput("reset dp", 32'(dp), 32'd1);
    checkOutput("reset scanTick", 32'(scanTick), 32'd0);
    checkOutput("reset anodeInv", 32'(anodeInv), 32'hF);

    // First slot after release: guard on edge 1, digit 0 on edge 2.
    rstN = 1'b1;
    tick();
    checkOutput("release e1 anode", 32'(anode), 32'hF);
    tick();
    checkOutput("release e2 anode", 32'(anode), 32'hE);
    checkOutput("release e2 scanTick", 32'(scanTick), 32'd0);

    // Plain scan of 1234.
    applyStimulus(16'h1234, 4'h0, 1'b0);
    checkScan(1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'hF, "scan1234");

    // Leading-zero blanking.
    applyStimulus(16'h0050, 4'h0, 1'b1);
    checkScan(1'b0, {7'h7F, 7'h7F, 7'b0010010, 7'b1000000}, 4'hF, "blank0050");
    applyStimulus(16'h0000, 4'b0011, 1'b1);
    checkScan(1'b0, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1110, "blank0000");

    // Inverted input on the second instance.
    applyStimulus(16'hFFFE, 4'b0001, 1'b0);
    checkScan(1'b1, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111001}, 4'b1110, "invert");

    // Load coinciding with the 3->0 wrap.
    waitScanTick();
    for (int k = 0; k < 15; k++) tick();
    value = 16'hABCD; dpIn = 4'h0; blankLead = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    checkOutput("wrapLoad scanTick", 32'(scanTick), 32'd1);
    checkOutput("wrapLoad old d3", 32'(disp), 32'b0001110);
    tick();
    checkOutput("wrapLoad new d0", 32'(disp), 32'b0100001);
    checkOutput("wrapLoad guard", 32'(anode), 32'hF);
    tick();
    tick();
    tick();
    checkOutput("wrapLoad d0 anode", 32'(anode), 32'hE);
    checkOutput("wrapLoad d0 disp", 32'(disp), 32'b0100001);

    // Enable dropped for six clocks mid-scan.
    waitScanTick();
    tick();
    tick();
    enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput($sformatf("disabled anode %0d", k), 32'(anode), 32'hF);
      checkOutput($sformatf("disabled scanTick %0d", k), 32'(scanTick), 32'd0);
    end
    enable = 1'b1;
    tick();
    tick();
    checkOutput("reenable anode", 32'(anode), 32'hB);
    n = 0;
    do begin
      tick();
      n++;
    end while (!scanTick && n < 40);
    checkOutput("reenable cadence", 32'(n), 32'd6);

    // Asynchronous reset between edges, with a load pending.
    tick();
    tick();
    checkOutput("prereset anode", 32'(anode), 32'hE);
    #2;
    rstN = 1'b0;
    value = 16'h1234;
    load = 1'b1;
    #1;
    checkOutput("async anode", 32'(anode), 32'hF);
    checkOutput("async disp", 32'(disp), 32'h7F);
    checkOutput("async dp", 32'(dp), 32'd1);
    tick();
    checkOutput("held anode", 32'(anode), 32'hF);
    load = 1'b0;
    rstN = 1'b1;
    tick();
    checkOutput("restart e1 anode", 32'(anode), 32'hF);
    tick();
    checkOutput("restart e2 anode", 32'(anode), 32'hE);
    checkOutput("restart shadow0", 32'(disp), 32'b1000000);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
